// File: rtl/pipelined_approx_rc_adder.sv
// Pipelined ripple-carry adder whose low APPROX_BITS positions use an approximate cell.
// Optional error monitor (exact-sum shadow pipeline, err_flag/err_cnt) enabled by macro RC_ERR_MON_EN.
module pipelined_approx_rc_adder #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter int APPROX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Out,
  output logic [15:0]      err_cnt,
  output logic             err_flag
);

  localparam int SEG = WIDTH / STAGES;

  // Adds one SEG-bit segment; global bit positions below APPROX_BITS use the
  // approximate cell (carry = X & ~Cin, sum = ~X & Y & ~Cin), the rest are full adders.
  function automatic logic [SEG:0] seg_add(input int k, input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y, input logic cin);
    logic             c;
    logic [SEG-1:0]   s;
    c = cin;
    s = '0;
    for (int j = 0; j < SEG; j++) begin
      if (k * SEG + j < APPROX_BITS) begin
        s[j] = ~x[j] & y[j] & ~c;
        c    = x[j] & ~c;
      end else begin
        s[j] = x[j] ^ y[j] ^ c;
        c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
      end
    end
    return {c, s};
  endfunction

  // Stage k register holds: operands shifted so the next segment sits at
  // [SEG-1:0], the partial sum of segments 0..k, and the carry out of segment k.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [SEG:0]      r    [STAGES];

  logic advance;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // pipeline advances when the output slot is empty or being taken (in_ready is
  // exactly that condition); otherwise every stage, including Out, holds.
  assign advance   = ~v_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign Out       = {c_q[STAGES-1], s_q[STAGES-1]};

  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = 1'b0;
    a_in[0] = IN1;
    b_in[0] = IN2;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k] = seg_add(k, a_in[k][SEG-1:0], b_in[k][SEG-1:0], c_in[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        // Data only moves with a valid token so Out keeps its last result across bubbles.
        if (v_in[k]) begin
          a_q[k] <= a_in[k] >> SEG;
          b_q[k] <= b_in[k] >> SEG;
          s_q[k] <= s_in[k] | (WIDTH'(r[k][SEG-1:0]) << (k * SEG));
          c_q[k] <= r[k][SEG];
        end
      end
    end
  end

`ifdef RC_ERR_MON_EN
  logic [WIDTH:0] ex_q  [STAGES];
  logic [WIDTH:0] ex_in [STAGES];
  logic [15:0]    cnt_q;
  logic           mismatch;

  always_comb begin
    ex_in[0] = {1'b0, IN1} + {1'b0, IN2};
    for (int k = 1; k < STAGES; k++) begin
      ex_in[k] = ex_q[k-1];
    end
  end

  assign mismatch = (Out != ex_q[STAGES-1]);
  assign err_flag = out_valid & mismatch;
  assign err_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ex_q[k] <= '0;
      end
    end else begin
      if (advance) begin
        for (int k = 0; k < STAGES; k++) begin
          if (v_in[k]) ex_q[k] <= ex_in[k];
        end
      end
      if (out_valid && out_ready && mismatch && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
`else
  assign err_cnt  = '0;
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_approx_rc_adder.sv
// Directed bench for pipelined_approx_rc_adder (WIDTH=16, STAGES=4, APPROX_BITS=1).
// Error-monitor expectations follow whether RC_ERR_MON_EN is defined for the build.
module tb_pipelined_approx_rc_adder;

`ifdef RC_ERR_MON_EN
  localparam logic MON = 1'b1;
`else
  localparam logic MON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] IN1;
  logic [15:0] IN2;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] Out;
  logic [15:0] err_cnt;
  logic        err_flag;

  pipelined_approx_rc_adder #(.WIDTH(16), .STAGES(4), .APPROX_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN2(IN2), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] o;
    logic        e;   // approximate result differs from the exact sum
  } vec_t;
  vec_t tbl [13];

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q [$];   // {expected err_flag, expected Out}
  logic [15:0] exp_cnt = '0;
  int hs_n = 0;
  int hs_first = 0;
  int hs_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every output handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = '0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got 0x%0h want no result", Out);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("out", 32'(Out), 32'(e[16:0]));
        check("err_flag", 32'(err_flag), 32'(e[17]));
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        if (e[17] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        hs_n++;
        if (hs_n == 1) hs_first = cyc;
        hs_last = cyc;
      end
    end
  end

  // driver: present a vector from a falling edge until it is accepted
  task automatic send(input vec_t v);
    int g = 0;
    IN1 = v.a;
    IN2 = v.b;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      exp_q.push_back({v.e & MON, v.o});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{16'h0001, 16'h0000, 17'h00002, 1'b1};
    tbl[1]  = '{16'h0000, 16'h0001, 17'h00001, 1'b0};
    tbl[2]  = '{16'h0001, 16'h0001, 17'h00002, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0001, 17'h10000, 1'b0};
    tbl[4]  = '{16'hFFFF, 16'h0000, 17'h10000, 1'b1};
    tbl[5]  = '{16'h0000, 16'h0000, 17'h00000, 1'b0};
    tbl[6]  = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0};
    tbl[7]  = '{16'h1234, 16'h4321, 17'h05555, 1'b0};
    tbl[8]  = '{16'h00FF, 16'h0100, 17'h00200, 1'b1};
    tbl[9]  = '{16'h8000, 16'h8000, 17'h10000, 1'b0};
    tbl[10] = '{16'h0003, 16'h0002, 17'h00006, 1'b1};
    tbl[11] = '{16'hABCD, 16'h1111, 17'h0BCDE, 1'b0};
    tbl[12] = '{16'h7FFF, 16'h0000, 17'h08000, 1'b1};

    // reset
    rst = 1'b1;
    in_valid = 1'b0;
    IN1 = '0;
    IN2 = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // latency of a single operation: out_valid in the 4th cycle after acceptance
    begin
      int lat = 1;
      send(tbl[0]);
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("latency", 32'(lat), 32'd4);
      @(negedge clk);
      check("err_cnt_after_first", 32'(err_cnt), 32'(MON));
    end

    // full table back to back, one result per cycle expected
    hs_n = 0;
    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();
    check("throughput_span", 32'(hs_last - hs_first), 32'd12);
    check("throughput_count", 32'(hs_n), 32'd13);

    // stall: four results queued, out_ready low for 3 cycles, junk offered meanwhile
    begin
      int g = 0;
      out_ready = 1'b0;
      for (int i = 8; i < 12; i++) send(tbl[i]);
      while (!out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      in_valid = 1'b1;
      IN1 = 16'h5555;
      IN2 = 16'h5555;
      for (int i = 0; i < 3; i++) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out", 32'(Out), 32'(tbl[8].o));
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
    end

    // reset two cycles after accepting two operations: both must vanish
    send(tbl[4]);
    send(tbl[8]);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_err_cnt", 32'(err_cnt), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);

    // recovery after reset
    send(tbl[12]);
    drain();
    @(negedge clk);
    check("final_err_cnt", 32'(err_cnt), 32'(MON));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
